// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types, defaults and frame-length rule for the bit stream serializer.
package serializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int unsigned DEFAULT_TICK_DIV = 100_000_000;
  function automatic int unsigned frame_len(input int unsigned len, input int unsigned width);
    return len == 0 ? width : len;
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: modulo-DIV counter; tick is registered so it is high exactly while the count sits at DIV-1.
module tick_divider #(
  parameter int unsigned DIV = 4
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int unsigned CW = DIV > 1 ? $clog2(DIV) : 1;
  logic [CW-1:0] count;
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      count <= '0;
      tick <= 1'b0;
    end else if (enable) begin
      count <= count == CW'(DIV - 1) ? '0 : count + 1'b1;
      tick <= count == CW'(DIV - 2);
    end else begin
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/bit_stream_serializer.sv
// bit_stream_serializer: shifts a captured pattern out MSB-first with a one-cycle strobe per bit period.
module bit_stream_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic             clock_100Mhz,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [WIDTH-1:0] pattern,
  input  logic [IDX_W-1:0] length,
  output logic             bit_out,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] bit_index,
  output logic [7:0]       frames_sent
);
  state_t state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] pat_reg;
  logic [IDX_W-1:0] last_idx;
  logic accept;
  assign accept = state == IDLE && start && !stop;
  assign busy = state == SHIFT;
  // shift_reg is zeroed on every exit to IDLE, so its MSB doubles as the registered serial output
  assign bit_out = shift_reg[WIDTH-1];
  tick_divider #(.DIV(TICK_DIV)) u_tick (
    .clock_100Mhz(clock_100Mhz),
    .reset       (reset),
    .clear       (accept),
    .enable      (state == SHIFT && !stop),
    .tick        (bit_strobe)
  );
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shift_reg <= '0;
      pat_reg <= '0;
      last_idx <= '0;
      bit_index <= '0;
      frames_sent <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state <= SHIFT;
        shift_reg <= pattern;
        pat_reg <= pattern;
        last_idx <= IDX_W'(frame_len(32'(length), WIDTH) - 1);
        bit_index <= '0;
      end else if (state == SHIFT && stop) begin
        state <= IDLE;
        shift_reg <= '0;
        bit_index <= '0;
      end else if (state == SHIFT && bit_strobe && bit_index == last_idx) begin
        frames_sent <= frames_sent + 8'd1;
        bit_index <= '0;
        shift_reg <= loop_en ? pat_reg : '0;
        state <= loop_en ? SHIFT : IDLE;
        done <= !loop_en;
      end else if (state == SHIFT && bit_strobe) begin
        shift_reg <= shift_reg << 1;
        bit_index <= bit_index + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bit_stream_serializer.sv
// tb_bit_stream_serializer: table-driven frames, corner sequences and random traffic against a timing-formula model.
module tb_bit_stream_serializer;
  logic clk = 0, reset = 1, start = 0, stop = 0, loop_en = 0;
  logic [15:0] pattern = '0;
  logic [3:0] length = '0;
  logic bit_out, bit_strobe, busy, done;
  logic [3:0] bit_index;
  logic [7:0] frames_sent;
  int tests = 0, fails = 0;
  bit m_act, m_done;
  int m_n, m_len, m_fr;
  logic [15:0] m_pat;
  logic [15:0] cap;
  int cnt, waited;
  bit seen;
  typedef struct {logic [15:0] pat; logic [3:0] len; logic [15:0] exp_bits; int exp_n;} vec_t;
  vec_t tbl[7];

  bit_stream_serializer #(.WIDTH(16), .IDX_W(4), .TICK_DIV(4)) dut (
    .clock_100Mhz(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .pattern(pattern), .length(length), .bit_out(bit_out), .bit_strobe(bit_strobe),
    .busy(busy), .done(done), .bit_index(bit_index), .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_done = 0; m_n = 0; m_len = 0; m_fr = 0; m_pat = '0;
  endtask

  // Model: a frame is just "n cycles since start"; bit k is on the line for cycles 4k+1..4k+4, strobed on the 4th.
  task automatic model_step();
    bit strb, last;
    strb = m_act && (m_n % 4 == 0);
    last = strb && ((m_n - 1) / 4 == m_len - 1);
    m_done = 0;
    if (reset) model_reset();
    else if (!m_act) begin
      if (start && !stop) begin
        m_act = 1; m_n = 1; m_pat = pattern; m_len = length == 0 ? 16 : int'(length);
      end
    end else if (stop) m_act = 0;
    else if (last) begin
      m_fr = (m_fr + 1) % 256;
      if (loop_en) m_n = 1;
      else begin m_act = 0; m_done = 1; end
    end else m_n++;
  endtask

  task automatic check_model();
    int idx;
    idx = m_act ? (m_n - 1) / 4 : 0;
    chk("busy", 32'(busy), 32'(m_act));
    chk("bit_strobe", 32'(bit_strobe), 32'(m_act && (m_n % 4 == 0)));
    chk("bit_index", 32'(bit_index), 32'(idx));
    chk("bit_out", 32'(bit_out), m_act ? 32'(m_pat[15-idx]) : 32'd0);
    chk("done", 32'(done), 32'(m_done));
    chk("frames_sent", 32'(frames_sent), 32'(m_fr));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic capture_until_done(input int limit);
    cap = '0; cnt = 0; waited = 0; seen = 0;
    while (!seen && waited < limit) begin
      cycle();
      waited++;
      if (bit_strobe) begin cap = {cap[14:0], bit_out}; cnt++; end
      if (done) seen = 1;
    end
  endtask

  task automatic run_frame(input int i);
    pattern = tbl[i].pat; length = tbl[i].len; loop_en = 0; stop = 0; start = 1;
    cycle();
    start = 0;
    capture_until_done(100);
    chk($sformatf("tbl%0d_bits", i), 32'(cap), 32'(tbl[i].exp_bits));
    chk($sformatf("tbl%0d_strobes", i), 32'(cnt), 32'(tbl[i].exp_n));
    chk($sformatf("tbl%0d_done_latency", i), 32'(waited), 32'(tbl[i].exp_n * 4));
    cycle();
  endtask

  initial begin
    int f0;
    tbl[0] = '{16'hB000, 4'd4, 16'h000B, 4};
    tbl[1] = '{16'hA5A5, 4'd0, 16'hA5A5, 16};
    tbl[2] = '{16'hC000, 4'd2, 16'h0003, 2};
    tbl[3] = '{16'h8001, 4'd0, 16'h8001, 16};
    tbl[4] = '{16'h7FFF, 4'd1, 16'h0000, 1};
    tbl[5] = '{16'h5000, 4'd3, 16'h0002, 3};
    tbl[6] = '{16'hFFFF, 4'd15, 16'h7FFF, 15};
    model_reset();
    #2;
    check_model();
    #10 reset = 0;
    cycle();
    run_frame(0);
    chk("frames_after_first", 32'(frames_sent), 32'd1);
    for (int i = 1; i < 7; i++) run_frame(i);
    // looping: frames_sent must wrap back after 256 frames of 8 cycles
    f0 = int'(frames_sent);
    pattern = 16'hC000; length = 4'd2; loop_en = 1; start = 1;
    cycle();
    start = 0;
    repeat (2048) cycle();
    chk("loop_wrap", 32'(frames_sent), 32'(f0));
    chk("loop_busy", 32'(busy), 32'd1);
    loop_en = 0;
    capture_until_done(20);
    chk("loop_exit_done", 32'(seen), 32'd1);
    cycle();
    // stop at t+6 of a 4-bit frame
    f0 = int'(frames_sent);
    pattern = 16'hB000; length = 4'd4; start = 1;
    cycle();
    start = 0; cnt = 0;
    repeat (5) begin cycle(); if (bit_strobe) cnt++; end
    stop = 1;
    cycle();
    stop = 0;
    chk("stop_strobes", 32'(cnt), 32'd1);
    chk("stop_idle", 32'(busy), 32'd0);
    chk("stop_no_done", 32'(done), 32'd0);
    chk("stop_frames", 32'(frames_sent), 32'(f0));
    repeat (3) cycle();
    // start held, pattern changed mid-frame; restart lands on the done cycle
    pattern = 16'h9000; length = 4'd4; start = 1;
    cycle();
    pattern = 16'h6000; length = 4'd2;
    capture_until_done(40);
    chk("held_bits", 32'(cap), 32'h9);
    chk("held_strobes", 32'(cnt), 32'd4);
    cycle();
    chk("held_restart_busy", 32'(busy), 32'd1);
    chk("held_restart_bit", 32'(bit_out), 32'd0);
    start = 0;
    capture_until_done(40);
    chk("held_second_bits", 32'(cap), 32'h1);
    cycle();
    // async reset mid-frame
    pattern = 16'hB000; length = 4'd4; start = 1;
    cycle();
    start = 0;
    repeat (6) cycle();
    #2 reset = 1;
    #1;
    model_reset();
    check_model();
    #2 reset = 0;
    cycle();
    run_frame(0);
    chk("post_reset_frames", 32'(frames_sent), 32'd1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom % 4) == 0;
      stop = ($urandom % 64) == 0;
      loop_en = ($urandom % 8) == 0;
      pattern = 16'($urandom);
      length = 4'($urandom);
      cycle();
    end
    start = 0; loop_en = 0; stop = 1;
    cycle();
    stop = 0;
    cycle();
    chk("final_idle", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bit_stream_serializer.md
# bit_stream_serializer

Transmitter-side counterpart to the sequence pattern detector. It loads a parallel pattern word and shifts it out MSB-first, one bit per bit period. Each bit is accompanied by a one-cycle strobe that the downstream detector uses as its sample enable. It replaces the ROM-address-stepping source, adding run-time pattern selection, variable frame length, looping and abort.

## Interface
Parameters:
- WIDTH, 16, maximum pattern length in bits
- IDX_W, 4, width of bit index and length fields; equals clog2(WIDTH)
- TICK_DIV, 100_000_000, clock cycles per bit period (1 s at 100 MHz); minimum 2

Ports:
- clock_100Mhz  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  level, sampled every cycle; begins a frame when idle
- stop  in  1  level; aborts an active frame
- loop_en  in  1  sampled at each frame end; 1 restarts the captured pattern
- pattern  in  WIDTH  pattern word, captured on accepted start
- length  in  IDX_W  number of bits per frame; 0 means WIDTH
- bit_out  out  1  current serial bit, stable for a whole bit period
- bit_strobe  out  1  one-cycle pulse; bit_out is valid to sample this cycle
- busy  out  1  high in SHIFT
- done  out  1  one-cycle pulse at normal (non-looping) frame completion
- bit_index  out  IDX_W  index within frame of the bit on bit_out (0 = MSB)
- frames_sent  out  8  count of completed frames, wraps 255 -> 0

## Operation
- States: IDLE, SHIFT. done is a registered pulse, not a state.
- IDLE, with start=1 and stop=0:
  - shift_reg <= pattern; len_reg <= (length==0 ? WIDTH : length).
  - tick counter <= 0, bit_index <= 0; go to SHIFT.
- IDLE, with start=1 and stop=1 in the same cycle: start is ignored; stay in IDLE.
- SHIFT:
  - bit_out = shift_reg[WIDTH-1].
  - The tick counter counts 0..TICK_DIV-1. bit_strobe=1 when the counter equals TICK_DIV-1, then the counter wraps to 0.
- On a cycle with bit_strobe=1 and bit_index < len_reg-1: shift_reg shifts left by one (zero fill) and bit_index increments; both take effect in the next cycle.
- On a cycle with bit_strobe=1 and bit_index == len_reg-1 (last bit), frames_sent increments, then:
  - loop_en=1: reload shift_reg from a captured copy of pattern (not the live input), bit_index <= 0, remain in SHIFT.
  - loop_en=0: go to IDLE, done=1 for the next cycle.
- stop=1 in SHIFT: go to IDLE next cycle.
  - No done pulse, no frames_sent increment.
  - A strobe in the same cycle as stop is still emitted; stop takes priority over shift or reload.
- start while busy is ignored; pattern and length changes during SHIFT have no effect.
- In IDLE: bit_out=0, bit_index=0, bit_strobe=0.
- Reset values: state IDLE; bit_out, bit_strobe, busy, done = 0; bit_index, frames_sent, tick counter, shift_reg = 0. Reset mid-frame discards the frame immediately.

## Timing
- Start accepted at edge t: busy=1 and bit 0 on bit_out from cycle t+1.
- Strobe for bit k falls in cycle t+(k+1)*TICK_DIV.
- Strobes are exactly TICK_DIV cycles apart, including across loop boundaries; no gap cycle on reload.
- After the last strobe, with no loop: busy=0 and done=1 in the next cycle. A new start is accepted in that same cycle.
- bit_out and bit_index change only in the cycle after a strobe.
- All outputs are registered.

## Structure
- Package serializer_pkg: state enum (IDLE, SHIFT), default TICK_DIV, and the length-0 means WIDTH rule as a function.
- Sub-module tick_divider:
  - Parameterized modulo-TICK_DIV counter with synchronous clear and a tick output.
  - Reusable for the display refresh and one-second enables.
- Top holds the FSM, shift register, captured pattern copy, index and frame counters.

## Test plan
All scenarios use TICK_DIV=4, WIDTH=16.
- Reset release, then start with pattern=16'hB000, length=4 -> bit_out sequence 1,0,1,1 at strobes in cycles t+4, t+8, t+12, t+16; done pulse at t+17; frames_sent=1.
- length=0, pattern=16'hA5A5 -> 16 strobes, serial sequence 1010010110100101, then done.
- loop_en=1, pattern=16'hC000, length=2 -> repeating 1,1,... with strobes spaced 4 cycles; frames_sent increments every 8 cycles and wraps after 256 frames.
- stop asserted at cycle t+6 of a 4-bit frame -> one strobe seen (bit 0); IDLE at t+7; no done; frames_sent unchanged.
- start held high and pattern changed during SHIFT -> no restart; original pattern output. start still high at the done cycle -> new frame begins with bit_out valid the next cycle.
- Reset asserted asynchronously mid-frame -> all outputs 0 immediately; start after release behaves like the first scenario.
